// File: rtl/sraml_arbiter_pkg.sv
// Shared definitions for the SRAM-like bus arbiter: FSM state encoding,
// owner encoding and a small owner helper.
// Optional build macro used elsewhere in this slice: SRAML_ARB_RR_EN.
package sraml_arbiter_pkg;

    // Arbiter FSM states. Encodings are fixed so waveforms read the same
    // across builds.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // no transaction in flight, arbitrate
        S_ADDR = 2'd1,  // request issued, waiting for m_addr_ok
        S_DATA = 2'd2   // address accepted, waiting for m_data_ok
    } arb_state_e;

    // Owner / winner encoding.
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // The requester that is not `own`.
    function automatic logic other_owner(input logic own);
        return (own == OWN_INST) ? OWN_DATA : OWN_INST;
    endfunction

endpackage

// File: rtl/sraml_arb_grant.sv
// Combinational grant decision for the SRAM-like arbiter.
// Build option: SRAML_ARB_RR_EN selects round-robin between the two
// requesters (the one that did not own the last transaction wins a tie);
// without it the data side has fixed priority and last_owner_i is ignored.
module sraml_arb_grant
    import sraml_arbiter_pkg::*;
(
    input  logic inst_req_i,
    input  logic data_req_i,
    input  logic last_owner_i,
    output logic winner_o
);

`ifdef SRAML_ARB_RR_EN

    // Round-robin: on a tie, hand the bus to whoever did not own it last.
    always_comb begin
        winner_o = OWN_INST;
        if (inst_req_i && data_req_i) begin
            winner_o = other_owner(last_owner_i);
        end else if (data_req_i) begin
            winner_o = OWN_DATA;
        end else begin
            winner_o = OWN_INST;
        end
    end

`else

    // History is still tracked by the top but plays no part in fixed mode.
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;

    // Fixed priority: a data request always beats an instruction request.
    // With no request at all the result is don't-care; inst is returned.
    always_comb begin
        winner_o = OWN_INST;
        if (data_req_i) begin
            winner_o = OWN_DATA;
        end else if (inst_req_i) begin
            winner_o = OWN_INST;
        end
    end

`endif

endmodule

// File: rtl/sraml_arbiter.sv
// Two-to-one SRAM-like bus arbiter: instruction and data requesters share a
// single SRAM-like master port toward the AXI bridge. One transaction is in
// flight at a time; the owner is locked from grant until data_ok so both
// handshakes return to the requester that issued the transaction.
// Build option: SRAML_ARB_RR_EN (round-robin tie-break, see sraml_arb_grant).
module sraml_arbiter
    import sraml_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    // Instruction-side requester
    input  logic              inst_req_i,
    input  logic              inst_wr_i,
    input  logic [1:0]        inst_size_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic [DATA_W-1:0] inst_wdata_i,
    output logic              inst_addr_ok_o,
    output logic              inst_data_ok_o,
    output logic [DATA_W-1:0] inst_rdata_o,

    // Data-side requester
    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [1:0]        data_size_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_addr_ok_o,
    output logic              data_data_ok_o,
    output logic [DATA_W-1:0] data_rdata_o,

    // Merged downstream port
    output logic              m_req_o,
    output logic              m_wr_o,
    output logic [1:0]        m_size_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic              m_addr_ok_i,
    input  logic              m_data_ok_i,
    input  logic [DATA_W-1:0] m_rdata_i
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;

    logic       any_req;
    logic       winner;
    logic       fwd_en;   // request phase: m_* carries a requester's fields
    logic       sel_own;  // requester whose fields are on m_* this cycle

    assign any_req = inst_req_i | data_req_i;

    sraml_arb_grant u_grant (
        .inst_req_i   (inst_req_i),
        .data_req_i   (data_req_i),
        .last_owner_i (last_owner_q),
        .winner_o     (winner)
    );

    // Request phase is the granting IDLE cycle or any ADDR cycle; in ADDR
    // the locked owner is used so a late arrival cannot steal the port.
    always_comb begin
        fwd_en  = 1'b0;
        sel_own = winner;
        case (state_q)
            S_IDLE: begin
                fwd_en  = any_req;
                sel_own = winner;
            end
            S_ADDR: begin
                fwd_en  = 1'b1;
                sel_own = owner_q;
            end
            default: begin
                fwd_en  = 1'b0;
                sel_own = owner_q;
            end
        endcase
    end

    // Next-state logic: grant in IDLE, wait for addr_ok, then data_ok.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    state_d = m_addr_ok_i ? S_DATA : S_ADDR;
                end
            end
            S_ADDR: begin
                // A requester that drops req here is not recovered: the
                // arbiter keeps forwarding its (now idle) fields.
                if (m_addr_ok_i) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // Back to IDLE; the next grant is decided one cycle later.
                if (m_data_ok_i) begin
                    last_owner_d = owner_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Forward the selected requester's fields downstream during request phase.
    always_comb begin
        m_req_o   = 1'b0;
        m_wr_o    = 1'b0;
        m_size_o  = '0;
        m_addr_o  = '0;
        m_wdata_o = '0;
        if (fwd_en) begin
            if (sel_own == OWN_DATA) begin
                m_req_o   = data_req_i;
                m_wr_o    = data_wr_i;
                m_size_o  = data_size_i;
                m_addr_o  = data_addr_i;
                m_wdata_o = data_wdata_i;
            end else begin
                m_req_o   = inst_req_i;
                m_wr_o    = inst_wr_i;
                m_size_o  = inst_size_i;
                m_addr_o  = inst_addr_i;
                m_wdata_o = inst_wdata_i;
            end
        end
    end

    // Route addr_ok to the requester whose fields are on the bus.
    always_comb begin
        inst_addr_ok_o = 1'b0;
        data_addr_ok_o = 1'b0;
        if (fwd_en) begin
            inst_addr_ok_o = (sel_own == OWN_INST) & m_addr_ok_i;
            data_addr_ok_o = (sel_own == OWN_DATA) & m_addr_ok_i;
        end
    end

    // Route data_ok/rdata to the locked owner only; m_data_ok seen outside
    // DATA is dropped so a stray pulse never reaches a requester.
    always_comb begin
        inst_data_ok_o = 1'b0;
        data_data_ok_o = 1'b0;
        inst_rdata_o   = '0;
        data_rdata_o   = '0;
        if (state_q == S_DATA) begin
            if (owner_q == OWN_DATA) begin
                data_data_ok_o = m_data_ok_i;
                data_rdata_o   = m_rdata_i;
            end else begin
                inst_data_ok_o = m_data_ok_i;
                inst_rdata_o   = m_rdata_i;
            end
        end
    end

    // State, owner and history registers; reset abandons any transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_INST;
            last_owner_q <= OWN_INST;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule
